id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage directly upstream of the ALU.
- Accepts a fetched MIPS instruction plus its register-file read data.
- Decodes the 16-bit one-hot ALU opcode, selects and extends the A/B operands, and registers the result with a valid/ready handshake.
- Its registered outputs drive the ALU A, B and ALUop inputs without further logic.

Parameters:
- DATA_WIDTH, 32, operand and PC width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  kill held and incoming instruction this cycle
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  DATA_WIDTH  instruction PC
- in_rs_data  in  DATA_WIDTH  GPR[rs]
- in_rt_data  in  DATA_WIDTH  GPR[rt]
- out_valid  out  1  registered entry valid
- out_ready  in  1  ALU/execute consumes entry
- out_alu_a  out  DATA_WIDTH  ALU A operand
- out_alu_b  out  DATA_WIDTH  ALU B operand
- out_alu_op  out  16  one-hot ALU opcode
- out_wb_en  out  1  result writes a GPR
- out_wb_reg  out  REG_ADDR_W  destination GPR
- out_ov_trap  out  1  overflow must trap (ADD/SUB/ADDI)
- out_mem_rd  out  1  LW
- out_mem_wr  out  1  SW
- out_store_data  out  DATA_WIDTH  rt data for SW
- out_pc  out  DATA_WIDTH  PC passthrough
- out_illegal  out  1  undecodable instruction

Behaviour:
- One-hot ALU opcode bit positions (bit index = op): AND 0, OR 1, ADD 2, SUB 3, SLT 4, XOR 5, NOR 6, SLTU 7, SLL 8, SRL 9, SRA 10, LUI 11, PASS_A 12, PASS_B 13. Bits 14–15 are always 0.
- Exactly one bit of out_alu_op is set whenever out_valid=1.
- R-type (op=0), dest=rd, A=rs, B=rt unless noted:
  - funct 20/21 -> ADD; 22/23 -> SUB; 24 -> AND; 25 -> OR; 26 -> XOR; 27 -> NOR; 2A -> SLT; 2B -> SLTU (hex).
  - funct 00/02/03 -> SLL/SRL/SRA with A={27'b0,shamt}.
  - funct 04/06/07 -> SLLV/SRLV/SRAV with A=rs (the ALU uses A[4:0] as the shift amount).
- I-type, dest=rt, A=rs:
  - 08/09 ADD, sign-extended imm.
  - 0A SLT, sign-extended imm.
  - 0B SLTU, sign-extended imm.
  - 0C AND, 0D OR, 0E XOR: zero-extended imm.
  - 0F LUI: B={16'b0,imm}.
  - 23 LW: ADD, sign-extended imm, mem_rd=1.
  - 2B SW: ADD, sign-extended imm, mem_wr=1, wb_en=0, store_data=rt.
- out_ov_trap=1 only for funct 20, funct 22, and opcode 08.
- Illegal (any other encoding):
  - alu_op=PASS_A, wb_en=0, mem_rd=mem_wr=0, out_illegal=1.
  - The instruction still flows through the handshake.
- wb_en is forced to 0 when the destination register is 0.
- Handshake:
  - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
  - Latency: 1 cycle from input transfer to out_valid.
  - Outputs hold stable while out_valid&&!out_ready.
- Base mode: single register. in_ready = !out_valid || out_ready (combinational from out_ready). Simultaneous consume and accept keeps out_valid=1 with the new data (full throughput).
- Flush (synchronous): next-cycle out_valid=0 and the incoming instruction is discarded. Flush has priority over capture; in_ready may be 1 during flush.
- Reset: out_valid=0 and all data outputs 0. A reset mid-stall discards the held entry; rst has priority over flush.
- Data outputs load only on input transfer. When out_valid=0 their values are don't-care to consumers but remain deterministic.

Optional Feature:
- Macro ID_EX_SKID_EN.
- Defined:
  - Adds a 1-entry skid buffer; in_ready becomes a registered output (= skid empty), so there is no combinational out_ready->in_ready path.
  - An input accepted while the main register is stalled goes to the skid. The skid drains into the main register on the next out_ready.
  - Throughput stays at 1 per cycle; order is preserved.
  - Flush clears both entries and sets in_ready=1 next cycle.
- Undefined: the base single-register behaviour above.

Test Plan:
- Reset then idle -> out_valid=0, alu_op=0, in_ready=1.
- inst 0x00221820 (add $3,$1,$2), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, alu_op=0x0004, A=5, B=7, wb_reg=3, wb_en=1, ov_trap=1.
- Immediate decode, one case per line:
  - inst 0x2401FFFF (addiu $1,$0,-1) -> alu_op=0x0004, B=0xFFFFFFFF, ov_trap=0.
  - inst 0x3401FFFF (ori) -> alu_op=0x0002, B=0x0000FFFF.
  - inst 0x3C011234 (lui) -> alu_op=0x0800, B=0x00001234.
- inst 0x00021100 (sll $2,$2,4) -> alu_op=0x0100, A=4, B=rt. inst 0x00000000 -> wb_en=0.
- Backpressure: hold out_ready=0 over 3 pushes -> base mode: in_ready=0 and outputs unchanged; release -> entries emerge in order with no loss or duplication. With ID_EX_SKID_EN: 2 entries are accepted before in_ready=0.
- Flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0. Opcode 0x3F -> out_illegal=1, alu_op=0x1000, wb_en=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: MIPS decode to one-hot ALU op, operand select, valid/ready register.
// Define ID_EX_SKID_EN to add a 1-entry skid buffer so in_ready is registered.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs_data,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu_a,
  output logic [DATA_WIDTH-1:0] out_alu_b,
  output logic [15:0]           out_alu_op,
  output logic                  out_wb_en,
  output logic [REG_ADDR_W-1:0] out_wb_reg,
  output logic                  out_ov_trap,
  output logic                  out_mem_rd,
  output logic                  out_mem_wr,
  output logic [DATA_WIDTH-1:0] out_store_data,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic                  out_illegal
);
  localparam int OP_AND = 0,  OP_OR  = 1,  OP_ADD = 2,  OP_SUB = 3,  OP_SLT  = 4;
  localparam int OP_XOR = 5,  OP_NOR = 6,  OP_SLTU = 7, OP_SLL = 8,  OP_SRL  = 9;
  localparam int OP_SRA = 10, OP_LUI = 11, OP_PASS_A = 12;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [15:0]           op;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic                  ov;
    logic                  mrd;
    logic                  mwr;
    logic [DATA_WIDTH-1:0] sd;
    logic [DATA_WIDTH-1:0] pc;
    logic                  ill;
  } ent_t;

  logic [5:0]            w_opc, w_funct;
  logic [4:0]            w_rt, w_rd, w_shamt, w_dest;
  logic [15:0]           w_imm;
  logic [DATA_WIDTH-1:0] w_sext, w_zext;
  logic                  w_legal, w_sw, w_unused_rs;
  ent_t                  w_dec, r_main;
  logic                  r_valid;

  assign w_opc       = in_inst[31:26];
  assign w_rt        = in_inst[20:16];
  assign w_rd        = in_inst[15:11];
  assign w_shamt     = in_inst[10:6];
  assign w_funct     = in_inst[5:0];
  assign w_imm       = in_inst[15:0];
  assign w_sext      = {{(DATA_WIDTH-16){w_imm[15]}}, w_imm};
  assign w_zext      = DATA_WIDTH'(w_imm);
  // rs operand arrives pre-read as in_rs_data; the index field itself is not needed
  assign w_unused_rs = ^in_inst[25:21];

  always_comb begin
    w_dec        = '0;
    w_legal      = 1'b1;
    w_sw         = 1'b0;
    w_dest       = (w_opc == 6'h00) ? w_rd : w_rt;
    w_dec.a      = in_rs_data;
    w_dec.b      = in_rt_data;
    w_dec.sd     = in_rt_data;
    w_dec.pc     = in_pc;
    w_dec.wb_reg = REG_ADDR_W'(w_dest);
    if (w_opc == 6'h00) begin
      case (w_funct)
        6'h20:   begin w_dec.op[OP_ADD] = 1'b1; w_dec.ov = 1'b1; end
        6'h21:   w_dec.op[OP_ADD]  = 1'b1;
        6'h22:   begin w_dec.op[OP_SUB] = 1'b1; w_dec.ov = 1'b1; end
        6'h23:   w_dec.op[OP_SUB]  = 1'b1;
        6'h24:   w_dec.op[OP_AND]  = 1'b1;
        6'h25:   w_dec.op[OP_OR]   = 1'b1;
        6'h26:   w_dec.op[OP_XOR]  = 1'b1;
        6'h27:   w_dec.op[OP_NOR]  = 1'b1;
        6'h2A:   w_dec.op[OP_SLT]  = 1'b1;
        6'h2B:   w_dec.op[OP_SLTU] = 1'b1;
        6'h00:   begin w_dec.op[OP_SLL] = 1'b1; w_dec.a = DATA_WIDTH'(w_shamt); end
        6'h02:   begin w_dec.op[OP_SRL] = 1'b1; w_dec.a = DATA_WIDTH'(w_shamt); end
        6'h03:   begin w_dec.op[OP_SRA] = 1'b1; w_dec.a = DATA_WIDTH'(w_shamt); end
        6'h04:   w_dec.op[OP_SLL]  = 1'b1;
        6'h06:   w_dec.op[OP_SRL]  = 1'b1;
        6'h07:   w_dec.op[OP_SRA]  = 1'b1;
        default: w_legal = 1'b0;
      endcase
    end else begin
      case (w_opc)
        6'h08:   begin w_dec.op[OP_ADD]  = 1'b1; w_dec.b = w_sext; w_dec.ov = 1'b1; end
        6'h09:   begin w_dec.op[OP_ADD]  = 1'b1; w_dec.b = w_sext; end
        6'h0A:   begin w_dec.op[OP_SLT]  = 1'b1; w_dec.b = w_sext; end
        6'h0B:   begin w_dec.op[OP_SLTU] = 1'b1; w_dec.b = w_sext; end
        6'h0C:   begin w_dec.op[OP_AND]  = 1'b1; w_dec.b = w_zext; end
        6'h0D:   begin w_dec.op[OP_OR]   = 1'b1; w_dec.b = w_zext; end
        6'h0E:   begin w_dec.op[OP_XOR]  = 1'b1; w_dec.b = w_zext; end
        6'h0F:   begin w_dec.op[OP_LUI]  = 1'b1; w_dec.b = w_zext; end
        6'h23:   begin w_dec.op[OP_ADD]  = 1'b1; w_dec.b = w_sext; w_dec.mrd = 1'b1; end
        6'h2B:   begin w_dec.op[OP_ADD]  = 1'b1; w_dec.b = w_sext; w_dec.mwr = 1'b1; w_sw = 1'b1; end
        default: w_legal = 1'b0;
      endcase
    end
    // undecodable words still flow downstream, as a side-effect-free PASS_A
    if (!w_legal) begin
      w_dec.op[OP_PASS_A] = 1'b1;
      w_dec.ill           = 1'b1;
    end
    w_dec.wb_en = w_legal && !w_sw && (w_dest != 5'd0);
  end

`ifdef ID_EX_SKID_EN
  ent_t r_skid;
  logic r_skid_vld;
  logic w_main_free, w_in_xfer;

  assign in_ready    = !r_skid_vld;
  assign w_main_free = !r_valid || out_ready;
  assign w_in_xfer   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_main     <= '0;
      r_skid_vld <= 1'b0;
      r_skid     <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_main_free) begin
      // a full skid implies in_ready=0, so it never races an incoming word
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_valid    <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_in_xfer) begin
        r_main  <= w_dec;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skid     <= w_dec;
      r_skid_vld <= 1'b1;
    end
  end
`else
  assign in_ready = !r_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_main  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_main  <= w_dec;
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
`endif

  assign out_valid      = r_valid;
  assign out_alu_a      = r_main.a;
  assign out_alu_b      = r_main.b;
  assign out_alu_op     = r_main.op;
  assign out_wb_en      = r_main.wb_en;
  assign out_wb_reg     = r_main.wb_reg;
  assign out_ov_trap    = r_main.ov;
  assign out_mem_rd     = r_main.mrd;
  assign out_mem_wr     = r_main.mwr;
  assign out_store_data = r_main.sd;
  assign out_pc         = r_main.pc;
  assign out_illegal    = r_main.ill;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed decode cases, backpressure/flush/reset, then random traffic vs a queue model.
module tb_id_ex_stage;
  localparam int DW = 32, RW = 5;
`ifdef ID_EX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_inst;
  logic [DW-1:0] in_pc, in_rs_data, in_rt_data;
  logic [DW-1:0] out_alu_a, out_alu_b, out_store_data, out_pc;
  logic [15:0]   out_alu_op;
  logic          out_wb_en, out_ov_trap, out_mem_rd, out_mem_wr, out_illegal;
  logic [RW-1:0] out_wb_reg;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_alu_op(out_alu_op),
    .out_wb_en(out_wb_en), .out_wb_reg(out_wb_reg), .out_ov_trap(out_ov_trap),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_store_data(out_store_data),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [DW-1:0] a, b, sd, pc;
    logic [15:0]   op;
    logic          wb_en, ov, mrd, mwr, ill;
    logic [RW-1:0] wb_reg;
  } exp_t;

  exp_t q[$];
  int n_pass = 0, n_tot = 0, n_acc = 0, n_out = 0;

  // Reference decode: pick the ALU op index from the instruction tables, then build operands.
  function automatic exp_t model_dec(logic [31:0] inst, logic [DW-1:0] rs, rt, pc);
    exp_t e;
    int k = -1;
    bit ov = 0, lw = 0, sw = 0, sh = 0, sx = 0;
    logic [5:0] opc = inst[31:26], fn = inst[5:0];
    logic [4:0] dest = (opc == 0) ? inst[15:11] : inst[20:16];
    if (opc == 0) begin
      case (fn)
        6'h20: begin k = 2; ov = 1; end
        6'h21: k = 2;
        6'h22: begin k = 3; ov = 1; end
        6'h23: k = 3;
        6'h24: k = 0;  6'h25: k = 1;  6'h26: k = 5;  6'h27: k = 6;
        6'h2A: k = 4;  6'h2B: k = 7;
        6'h00: begin k = 8;  sh = 1; end
        6'h02: begin k = 9;  sh = 1; end
        6'h03: begin k = 10; sh = 1; end
        6'h04: k = 8;  6'h06: k = 9;  6'h07: k = 10;
        default: k = -1;
      endcase
    end else begin
      case (opc)
        6'h08: begin k = 2; sx = 1; ov = 1; end
        6'h09: begin k = 2; sx = 1; end
        6'h0A: begin k = 4; sx = 1; end
        6'h0B: begin k = 7; sx = 1; end
        6'h0C: k = 0;  6'h0D: k = 1;  6'h0E: k = 5;  6'h0F: k = 11;
        6'h23: begin k = 2; sx = 1; lw = 1; end
        6'h2B: begin k = 2; sx = 1; sw = 1; end
        default: k = -1;
      endcase
    end
    e.a      = sh ? DW'(inst[10:6]) : rs;
    if (opc == 0 || k < 0) e.b = rt;
    else if (sx)           e.b = DW'($signed(inst[15:0]));
    else                   e.b = DW'(inst[15:0]);
    e.op     = (k < 0) ? 16'h1000 : (16'h1 << k);
    e.ill    = (k < 0);
    e.ov     = ov;
    e.mrd    = lw;
    e.mwr    = sw;
    e.wb_reg = RW'(dest);
    e.wb_en  = (k >= 0) && !sw && (dest != 0);
    e.sd     = rt;
    e.pc     = pc;
    return e;
  endfunction

  function automatic logic exp_rdy();
`ifdef ID_EX_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  function automatic logic [5:0] pick_funct(int k);
    case (k)
      0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
      4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
      8: return 6'h2A;  9: return 6'h2B;  10: return 6'h00; 11: return 6'h02;
      12: return 6'h03; 13: return 6'h04; 14: return 6'h06; 15: return 6'h07;
      default: return 6'h01;
    endcase
  endfunction

  function automatic logic [5:0] pick_opc(int k);
    case (k)
      0: return 6'h08; 1: return 6'h09; 2: return 6'h0A; 3: return 6'h0B; 4: return 6'h0C;
      5: return 6'h0D; 6: return 6'h0E; 7: return 6'h0F; 8: return 6'h23; default: return 6'h2B;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    int s = $urandom_range(0, 9);
    if (s < 4) begin
      w[31:26] = 6'h00;
      w[5:0]   = pick_funct($urandom_range(0, 16));
    end else if (s < 9) begin
      w[31:26] = pick_opc($urandom_range(0, 9));
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tot++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs on the falling edge.
  task automatic cycle();
    exp_t e;
    logic in_x, out_x;
    #1;
    chk("in_ready", in_ready, exp_rdy());
    in_x  = in_valid && exp_rdy();
    out_x = (q.size() > 0) && out_ready;
    e     = model_dec(in_inst, in_rs_data, in_rt_data, in_pc);
    @(posedge clk);
    if (rst || flush) q.delete();
    else begin
      if (out_x) begin void'(q.pop_front()); n_out++; end
      if (in_x)  begin q.push_back(e); n_acc++; end
    end
    @(negedge clk);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("alu_a", out_alu_a, q[0].a);
      chk("alu_b", out_alu_b, q[0].b);
      chk("alu_op", out_alu_op, q[0].op);
      chk("onehot", 64'($countones(out_alu_op)), 1);
      chk("wb_en", out_wb_en, q[0].wb_en);
      chk("wb_reg", out_wb_reg, q[0].wb_reg);
      chk("ov_trap", out_ov_trap, q[0].ov);
      chk("mem_rd", out_mem_rd, q[0].mrd);
      chk("mem_wr", out_mem_wr, q[0].mwr);
      chk("store_data", out_store_data, q[0].sd);
      chk("pc", out_pc, q[0].pc);
      chk("illegal", out_illegal, q[0].ill);
    end
  endtask

  task automatic push(input logic [31:0] inst, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
    in_valid   = 1'b1;
    in_inst    = inst;
    in_rs_data = rs;
    in_rt_data = rt;
    in_pc      = $urandom;
    cycle();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_rs_data = '0; in_rt_data = '0;
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_op", out_alu_op, 0);
    chk("rst_a", out_alu_a, 0);
    chk("rst_b", out_alu_b, 0);
    chk("rst_pc", out_pc, 0);
    cycle();
    chk("idle_in_ready", in_ready, 1);

    out_ready = 1'b1;
    push(32'h00221820, 32'd5, 32'd7);
    chk("add_valid", out_valid, 1);
    chk("add_op", out_alu_op, 16'h0004);
    chk("add_a", out_alu_a, 5);
    chk("add_b", out_alu_b, 7);
    chk("add_wb_reg", out_wb_reg, 3);
    chk("add_wb_en", out_wb_en, 1);
    chk("add_ov", out_ov_trap, 1);
    push(32'h2401FFFF, $urandom, $urandom);
    chk("addiu_op", out_alu_op, 16'h0004);
    chk("addiu_b", out_alu_b, 32'hFFFFFFFF);
    chk("addiu_ov", out_ov_trap, 0);
    push(32'h3401FFFF, $urandom, $urandom);
    chk("ori_op", out_alu_op, 16'h0002);
    chk("ori_b", out_alu_b, 32'h0000FFFF);
    push(32'h3C011234, $urandom, $urandom);
    chk("lui_op", out_alu_op, 16'h0800);
    chk("lui_b", out_alu_b, 32'h00001234);
    push(32'h00021100, 32'd9, 32'h0000ABCD);
    chk("sll_op", out_alu_op, 16'h0100);
    chk("sll_a", out_alu_a, 4);
    chk("sll_b", out_alu_b, 32'h0000ABCD);
    push(32'h00000000, $urandom, $urandom);
    chk("nop_wb_en", out_wb_en, 0);
    push(32'hFC220000, $urandom, $urandom);
    chk("ill_flag", out_illegal, 1);
    chk("ill_op", out_alu_op, 16'h1000);
    chk("ill_wb_en", out_wb_en, 0);
    in_valid = 1'b0;
    cycle();

    // backpressure: three offered words against a stalled consumer
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 3; i++) push(rand_inst(), $urandom, $urandom);
    chk("bp_accepted", n_acc, CAP);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_out = 0;
    repeat (3) cycle();
    chk("bp_drained", n_out, CAP);

    // flush with a held entry and a new word offered
    out_ready = 1'b0;
    push(rand_inst(), $urandom, $urandom);
    flush = 1'b1;
    push(rand_inst(), $urandom, $urandom);
    chk("flush_valid", out_valid, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("flush_in_ready", in_ready, 1);

    // reset while stalled discards the entry
    push(rand_inst(), $urandom, $urandom);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_stall_valid", out_valid, 0);
    chk("rst_stall_op", out_alu_op, 0);
    chk("rst_stall_a", out_alu_a, 0);

    repeat (600) begin
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_inst    = rand_inst();
      in_rs_data = $urandom;
      in_rt_data = $urandom;
      in_pc      = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
